// File: rtl/rgb_pattern_gen_if.sv
// Video output bundle of the pattern generator: syncs, data-enable, colour and
// the frame-start marker, in the format the HDMI input path consumes.
interface rgb_pattern_gen_if;
  logic       O_rgb_vs;
  logic       O_rgb_hs;
  logic       O_rgb_de;
  logic [7:0] O_rgb_r;
  logic [7:0] O_rgb_g;
  logic [7:0] O_rgb_b;
  logic       O_frame_start;

  modport master (output O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b, O_frame_start);
  modport slave  (input  O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b, O_frame_start);
endinterface

// File: rtl/rgb_pattern_gen.sv
// Raster timing generator with solid / ramp / colour-bar / checkerboard test
// patterns; every output is registered one cycle behind the h/v counters.
module rgb_pattern_gen #(
  parameter int H_ACTIVE = 16,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 4,
  parameter int H_BACK   = 2,
  parameter int V_ACTIVE = 4,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 1,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_enable,
  input  logic [1:0]  I_pattern,
  input  logic [23:0] I_solid_rgb,
  output logic        O_busy,
  rgb_pattern_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // Counters are at least 8 bits wide so the ramp can take h[7:0]/v[7:0] directly.
  localparam int HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam int BW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic [7:0]    fcnt, fcnt_e;
  logic          seen;
  logic [1:0]    pat_q, pat_e;
  logic [23:0]   sol_q, sol_e;
  logic          fs, de_d, hs_d, vs_d;
  logic [23:0]   rgb_d;
  logic [2:0]    bar;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state <= IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_nxt;
      h     <= h_nxt;
      v     <= v_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    v_nxt     = v;
    if (state == IDLE) begin
      h_nxt = '0;
      v_nxt = '0;
      if (I_enable) state_nxt = RUN;
    end else if (h == H_LAST) begin
      h_nxt = '0;
      if (v == V_LAST) begin
        v_nxt = '0;
        // enable is only honoured at the frame boundary
        if (!I_enable) state_nxt = IDLE;
      end else begin
        v_nxt = v + VW'(1);
      end
    end else begin
      h_nxt = h + HW'(1);
    end
  end

  always_comb begin
    fs     = (state == RUN) && (h == '0) && (v == '0);
    // the first pixel of a frame already uses the values being latched
    pat_e  = fs ? I_pattern : pat_q;
    sol_e  = fs ? I_solid_rgb : sol_q;
    fcnt_e = (fs && seen) ? fcnt + 8'd1 : fcnt;
    de_d   = (state == RUN) && (h < H_ACT) && (v < V_ACT);
    hs_d   = ((state == RUN) && (h >= HS_BEG) && (h < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_d   = ((state == RUN) && (v >= VS_BEG) && (v < VS_END)) ? SYNC_POL : ~SYNC_POL;
    bar    = '0;
    for (int k = 1; k < 8; k++)
      if (h >= HW'(k * BW)) bar = bar + 3'd1;
    case (pat_e)
      2'd0:    rgb_d = sol_e;
      2'd1:    rgb_d = {h[7:0], v[7:0], fcnt_e};
      // bar index bits map straight onto channel enables: ~[1]=R, ~[2]=G, ~[0]=B
      2'd2:    rgb_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      default: rgb_d = {24{h[3] ^ v[3] ^ fcnt_e[0]}};
    endcase
    if (!de_d) rgb_d = '0;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      fcnt              <= '0;
      seen              <= 1'b0;
      pat_q             <= '0;
      sol_q             <= '0;
      O_busy            <= 1'b0;
      vid.O_rgb_de      <= 1'b0;
      vid.O_rgb_hs      <= ~SYNC_POL;
      vid.O_rgb_vs      <= ~SYNC_POL;
      vid.O_rgb_r       <= '0;
      vid.O_rgb_g       <= '0;
      vid.O_rgb_b       <= '0;
      vid.O_frame_start <= 1'b0;
    end else begin
      O_busy            <= (state == RUN);
      vid.O_rgb_de      <= de_d;
      vid.O_rgb_hs      <= hs_d;
      vid.O_rgb_vs      <= vs_d;
      vid.O_rgb_r       <= rgb_d[23:16];
      vid.O_rgb_g       <= rgb_d[15:8];
      vid.O_rgb_b       <= rgb_d[7:0];
      vid.O_frame_start <= fs;
      if (fs) begin
        pat_q <= I_pattern;
        sol_q <= I_solid_rgb;
        fcnt  <= fcnt_e;
        seen  <= 1'b1;
      end
    end
  end
endmodule

// File: doc/rgb_pattern_gen.md
RGB_PATTERN_GEN -- requirements
Module: rgb_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 16: active pixels per line.
REQ-002 Parameters H_FRONT / H_SYNC / H_BACK, defaults 2 / 4 / 2: horizontal blanking segments in clocks.
REQ-003 Parameter V_ACTIVE, default 4: active lines per frame.
REQ-004 Parameters V_FRONT / V_SYNC / V_BACK, defaults 1 / 2 / 1: vertical blanking segments in lines.
REQ-005 Parameter SYNC_POL, default 1: active level of O_rgb_hs and O_rgb_vs.
REQ-006 I_clk  in  1  pixel clock, the single clock; all logic on its rising edge.
REQ-007 I_rst_n  in  1  reset, synchronous and active-low.
REQ-008 I_enable  in  1  run request, level-sensitive.
REQ-009 I_pattern  in  2  0 solid, 1 ramp, 2 colour bars, 3 checkerboard.
REQ-010 I_solid_rgb  in  24  solid colour {R[23:16],G[15:8],B[7:0]}.
REQ-011 O_rgb_vs, O_rgb_hs, O_rgb_de  out  1 each  sync and data-enable, same format the HDMI input path consumes.
REQ-012 O_rgb_r, O_rgb_g, O_rgb_b  out  8 each  pixel colour.
REQ-013 O_frame_start  out  1  one-cycle pulse on first pixel of each frame.
REQ-014 O_busy  out  1  high while not IDLE.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) wrap; v increments when h wraps.
REQ-016 Line order: active, front porch, sync, back porch; frame order identical in lines.
REQ-017 de = (h < H_ACTIVE) and (v < V_ACTIVE); hs active for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC; vs active for whole lines V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC.
REQ-018 All outputs registered; each output reflects the counter state of the previous cycle (latency 1).
REQ-019 States IDLE, RUN; IDLE -> RUN when I_enable=1, counters start at h=v=0 on the first RUN cycle.
REQ-020 In RUN, at h=H_TOTAL-1, v=V_TOTAL-1: stay in RUN if I_enable=1, else go IDLE; deassertion mid-frame completes the frame.
REQ-021 In IDLE: de=0, hs and vs inactive (!SYNC_POL), RGB=0, counters held at 0.
REQ-022 I_pattern and I_solid_rgb sampled only at frame start (h=v=0) into registers; mid-frame changes take effect next frame.
REQ-023 An 8-bit frame counter increments at each frame start after the first, wrapping 255->0; cleared by reset only.
REQ-024 Pattern 0: RGB = latched I_solid_rgb.
REQ-025 Pattern 1: R = h[7:0], G = v[7:0], B = frame counter.
REQ-026 Pattern 2: bar width BW = H_ACTIVE/8 (integer, min 1); bar index = h/BW saturated at 7, computed without division; colours 0..7 white, yellow, cyan, green, magenta, red, blue, black (full-scale 8'hFF/8'h00).
REQ-027 Pattern 3: white when h[3]^v[3]^frame_counter[0] = 1, else black.
REQ-028 RGB = 0 whenever de = 0, for every pattern.
REQ-029 O_frame_start pulses with the de-high pixel at h=v=0 only.

Reset
REQ-030 I_rst_n=0 at a clock edge: next cycle state IDLE, counters 0, frame counter 0, O_rgb_de=0, O_rgb_hs=O_rgb_vs=!SYNC_POL, RGB=0, O_frame_start=0, O_busy=0.
REQ-031 Reset mid-frame aborts immediately; no frame completion.
REQ-032 Reset dominates I_enable in the same cycle.

Verification
REQ-033 Defaults, I_enable=1 held -> one frame = 192 cycles; per line 16 de-high, hs active cycles 18..21; vs active lines 5..6; O_frame_start every 192 cycles.
REQ-034 Pattern 0, I_solid_rgb=24'h123456 -> all 64 active pixels 12/34/56, blanking 0/0/0.
REQ-035 Pattern 2 -> pixel pairs (h=0,1) FF/FF/FF, (h=14,15) 00/00/00, (h=2,3) FF/FF/00.
REQ-036 Pattern 1, 3 frames -> B = 0,1,2 across frames; pixel h=5,v=2 gives R=5, G=2.
REQ-037 I_enable dropped at h=3,v=1 -> frame completes, O_busy low after cycle 192, outputs idle; I_pattern changed mid-frame -> applied from next frame start.
REQ-038 I_rst_n pulsed low for 1 cycle at h=10,v=2 -> REQ-030 values next cycle; with I_enable=1, new frame starts at h=v=0 one cycle later.
